// File: rtl/strassen_pkg.sv
// Shared definitions for the 2x2 Strassen sequencer.
//   - ALU command encodings driven on each 3-bit alu_cmd field.
//   - Operand source codes driven on each 2-bit sel_a / sel_b field.
//   - Sequencer state encoding, also consumed by the phase decoder.
package strassen_pkg;

    localparam int N_ALU   = 10;
    localparam int STATE_W = 4;

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_MUL = 3'd2;
    localparam logic [2:0] CMD_NOP = 3'd7;

    localparam logic [1:0] SRC_RAW  = 2'd0;
    localparam logic [1:0] SRC_SUM  = 2'd1;
    localparam logic [1:0] SRC_PROD = 2'd2;
    localparam logic [1:0] SRC_PART = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_LDW   = 4'd2,
        ST_SUM   = 4'd3,
        ST_MUL   = 4'd4,
        ST_COMB1 = 4'd5,
        ST_COMB2 = 4'd6,
        ST_STORE = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

endpackage

// File: rtl/strassen_phase_decode.sv
// Combinational phase decoder: maps the sequencer state onto the ten ALU
// commands and their A/B operand-source selects.
//   state_i    in   current (effective) sequencer state
//   alu_cmd_o  out  ALU k command at [3k+2:3k]
//   sel_a_o    out  ALU k A-source at [2k+1:2k]
//   sel_b_o    out  ALU k B-source at [2k+1:2k]
// ALUs not used in a phase get NOP with both selects at 0.
module strassen_phase_decode
    import strassen_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    output logic [29:0]        alu_cmd_o,
    output logic [19:0]        sel_a_o,
    output logic [19:0]        sel_b_o
);

    logic [2:0] cmd [N_ALU];
    logic [1:0] sa  [N_ALU];
    logic [1:0] sb  [N_ALU];

    always_comb begin
        for (int k = 0; k < N_ALU; k++) begin
            cmd[k] = CMD_NOP;
            sa[k]  = SRC_RAW;
            sb[k]  = SRC_RAW;
        end
        case (state_i)
            ST_SUM: begin
                // S1..S10 straight from the raw A/B registers
                cmd[0] = CMD_SUB; cmd[1] = CMD_ADD; cmd[2] = CMD_ADD;
                cmd[3] = CMD_SUB; cmd[4] = CMD_ADD; cmd[5] = CMD_ADD;
                cmd[6] = CMD_SUB; cmd[7] = CMD_ADD; cmd[8] = CMD_SUB;
                cmd[9] = CMD_ADD;
            end
            ST_MUL: begin
                for (int k = 0; k < 7; k++) cmd[k] = CMD_MUL;
                // P1 = A11*S1, P2 = S2*B22, P3 = S3*B11, P4 = A22*S4, P5..P7 = S*S
                sb[0] = SRC_SUM;
                sa[1] = SRC_SUM;
                sa[2] = SRC_SUM;
                sb[3] = SRC_SUM;
                for (int k = 4; k < 7; k++) begin
                    sa[k] = SRC_SUM;
                    sb[k] = SRC_SUM;
                end
            end
            ST_COMB1: begin
                for (int k = 0; k < 6; k++) begin
                    cmd[k] = CMD_ADD;
                    sa[k]  = SRC_PROD;
                    sb[k]  = SRC_PROD;
                end
                cmd[1] = CMD_SUB;  // T2 = P6 - P2
            end
            ST_COMB2: begin
                // C11 = T1 + T2, C22 = T5 - T6; C12/C21 bypass the ALUs
                cmd[0] = CMD_ADD; sa[0] = SRC_PART; sb[0] = SRC_PART;
                cmd[4] = CMD_SUB; sa[4] = SRC_PART; sb[4] = SRC_PART;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_cmd_o = '0;
        sel_a_o   = '0;
        sel_b_o   = '0;
        for (int k = 0; k < N_ALU; k++) begin
            alu_cmd_o[3*k +: 3] = cmd[k];
            sel_a_o[2*k +: 2]   = sa[k];
            sel_b_o[2*k +: 2]   = sb[k];
        end
    end

endmodule

// File: rtl/strassen_seq.sv
// Sequencer for one 2x2 Strassen block multiply C = A*B.
//   clk, reset       clock, synchronous active-high reset
//   start            request a multiply (only looked at in IDLE)
//   stall            freeze the sequencer for this cycle
//   busy / done      busy from LOAD through DONE; done pulses when C is written
//   mem_addr1/2      dual-port memory addresses, mem_we writes both ports
//   wr_sel           0: C11/C12 onto the write data, 1: C21/C22
//   ld_en            one-hot capture of read pair k into the raw registers
//   s_le/p_le/t_le/c_le  latch enables for sums, products, partials, result
//   alu_cmd/sel_a/sel_b  per-ALU command and operand-source fields
// Protocol: start is a request level sampled in IDLE; acceptance is the edge
// leaving IDLE. Exactly one done pulse follows each accepted start unless
// reset intervenes.
module strassen_seq
    import strassen_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int A_BASE  = 0,
    parameter int B_BASE  = 4,
    parameter int C_BASE  = 8,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic [ADDR_W-1:0] mem_addr2,
    output logic              mem_we,
    output logic              wr_sel,
    output logic [3:0]        ld_en,
    output logic              s_le,
    output logic              p_le,
    output logic              t_le,
    output logic              c_le,
    output logic [29:0]       alu_cmd,
    output logic [19:0]       sel_a,
    output logic [19:0]       sel_b
);

    localparam int CNT_W = $clog2(MUL_LAT + 4);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             restart_q, restart_d;

    // Effective state/counter seen by the output logic. A stall during the
    // load phase drops an in-flight read, so the first unstalled cycle
    // afterwards behaves as LOAD cnt=0 while the held values stay visible
    // for the duration of the stall.
    state_t           cur_state;
    logic [CNT_W-1:0] cur_cnt;
    logic             live;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            restart_q <= restart_d;
        end
    end

    always_comb begin
        live      = !stall;
        cur_state = state_q;
        cur_cnt   = cnt_q;
        if (restart_q && live) begin
            cur_state = ST_LOAD;
            cur_cnt   = '0;
        end
    end

    always_comb begin
        state_d   = cur_state;
        cnt_d     = cur_cnt;
        restart_d = restart_q;
        if (!live) begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (state_q == ST_LOAD || state_q == ST_LDW) restart_d = 1'b1;
        end else begin
            restart_d = 1'b0;
            case (cur_state)
                ST_IDLE: if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
                ST_LOAD: begin
                    if (cur_cnt == CNT_W'(3)) begin
                        state_d = ST_LDW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cur_cnt + 1'b1;
                    end
                end
                ST_LDW:  state_d = ST_SUM;
                ST_SUM: begin
                    state_d = ST_MUL;
                    cnt_d   = '0;
                end
                ST_MUL: begin
                    if (cur_cnt == CNT_W'(MUL_LAT - 1)) begin
                        state_d = ST_COMB1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cur_cnt + 1'b1;
                    end
                end
                ST_COMB1: state_d = ST_COMB2;
                ST_COMB2: begin
                    state_d = ST_STORE;
                    cnt_d   = '0;
                end
                ST_STORE: begin
                    if (cur_cnt == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cur_cnt + 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (cur_state != ST_IDLE);
        done      = 1'b0;
        mem_we    = 1'b0;
        wr_sel    = 1'b0;
        ld_en     = '0;
        s_le      = 1'b0;
        p_le      = 1'b0;
        t_le      = 1'b0;
        c_le      = 1'b0;
        mem_addr1 = '0;
        mem_addr2 = '0;
        case (cur_state)
            ST_LOAD: begin
                case (cur_cnt[1:0])
                    2'd0: begin
                        mem_addr1 = ADDR_W'(A_BASE);
                        mem_addr2 = ADDR_W'(A_BASE + 1);
                    end
                    2'd1: begin
                        mem_addr1 = ADDR_W'(A_BASE + 2);
                        mem_addr2 = ADDR_W'(A_BASE + 3);
                    end
                    2'd2: begin
                        mem_addr1 = ADDR_W'(B_BASE);
                        mem_addr2 = ADDR_W'(B_BASE + 1);
                    end
                    default: begin
                        mem_addr1 = ADDR_W'(B_BASE + 2);
                        mem_addr2 = ADDR_W'(B_BASE + 3);
                    end
                endcase
                // read data lags its address by one cycle
                if (cur_cnt[1:0] != 2'd0)
                    ld_en = {3'b000, live} << (cur_cnt[1:0] - 2'd1);
            end
            ST_LDW:   ld_en = {live, 3'b000};
            ST_SUM:   s_le  = live;
            ST_MUL:   p_le  = live && (cur_cnt == CNT_W'(MUL_LAT - 1));
            ST_COMB1: t_le  = live;
            ST_COMB2: c_le  = live;
            ST_STORE: begin
                mem_we = live;
                if (cur_cnt[0]) begin
                    mem_addr1 = ADDR_W'(C_BASE + 2);
                    mem_addr2 = ADDR_W'(C_BASE + 3);
                    wr_sel    = 1'b1;
                end else begin
                    mem_addr1 = ADDR_W'(C_BASE);
                    mem_addr2 = ADDR_W'(C_BASE + 1);
                end
            end
            ST_DONE:  done = live;
            default: ;
        endcase
    end

    strassen_phase_decode u_decode (
        .state_i   (cur_state),
        .alu_cmd_o (alu_cmd),
        .sel_a_o   (sel_a),
        .sel_b_o   (sel_b)
    );

endmodule

// File: tb/tb_strassen_seq.sv
module tb_strassen_seq;
  import strassen_pkg::*;

  localparam int AW = 4;
  localparam logic [29:0] NOP_ALL = {10{3'b111}};
  localparam logic [29:0] MUL_WORD = {3'd7, 3'd7, 3'd7, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0, stall = 1'b0, start1 = 1'b0, start5 = 1'b0;
  logic no_stall = 1'b0;
  logic mem_init = 1'b0;

  logic busy, done, mem_we, wr_sel, s_le, p_le, t_le, c_le;
  logic [AW-1:0] mem_addr1, mem_addr2;
  logic [3:0] ld_en;
  logic [29:0] alu_cmd;
  logic [19:0] sel_a, sel_b;

  logic busy1, done1, we1, ws1, sle1, ple1, tle1, cle1;
  logic [AW-1:0] a1_1, a2_1;
  logic [3:0] ld1;
  logic [29:0] cmd1;
  logic [19:0] sa1, sb1;

  logic busy5, done5, we5, ws5, sle5, ple5, tle5, cle5;
  logic [AW-1:0] a1_5, a2_5;
  logic [3:0] ld5;
  logic [29:0] cmd5;
  logic [19:0] sa5, sb5;

  strassen_seq #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .busy(busy), .done(done), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_we(mem_we), .wr_sel(wr_sel), .ld_en(ld_en), .s_le(s_le), .p_le(p_le),
    .t_le(t_le), .c_le(c_le), .alu_cmd(alu_cmd), .sel_a(sel_a), .sel_b(sel_b)
  );

  strassen_seq #(.ADDR_W(AW), .A_BASE(14), .MUL_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset), .start(start1), .stall(no_stall),
    .busy(busy1), .done(done1), .mem_addr1(a1_1), .mem_addr2(a2_1),
    .mem_we(we1), .wr_sel(ws1), .ld_en(ld1), .s_le(sle1), .p_le(ple1),
    .t_le(tle1), .c_le(cle1), .alu_cmd(cmd1), .sel_a(sa1), .sel_b(sb1)
  );

  strassen_seq #(.ADDR_W(AW), .A_BASE(14), .MUL_LAT(5)) dut_l5 (
    .clk(clk), .reset(reset), .start(start5), .stall(no_stall),
    .busy(busy5), .done(done5), .mem_addr1(a1_5), .mem_addr2(a2_5),
    .mem_we(we5), .wr_sel(ws5), .ld_en(ld5), .s_le(sle5), .p_le(ple5),
    .t_le(tle5), .c_le(cle5), .alu_cmd(cmd5), .sel_a(sa5), .sel_b(sb5)
  );

  // ---------------- datapath + memory model ----------------
  // raw: 0 A11, 1 A12, 2 A21, 3 A22, 4 B11, 5 B12, 6 B21, 7 B22
  localparam int SUM_A [10] = '{5, 0, 2, 6, 0, 4, 1, 6, 0, 4};
  localparam int SUM_B [10] = '{7, 1, 3, 4, 3, 7, 3, 7, 2, 5};
  // index into raw when sel is RAW, into S when sel is SUM
  localparam int MUL_A [7] = '{0, 1, 2, 3, 4, 6, 8};
  localparam int MUL_B [7] = '{0, 7, 4, 3, 5, 7, 9};
  localparam int CB1_A [6] = '{4, 5, 0, 2, 4, 2};
  localparam int CB1_B [6] = '{3, 1, 1, 3, 0, 6};
  localparam int BAD = 12345;

  int mem [16];
  int rd1_q, rd2_q;
  int raw [8];
  int s [10];
  int p [7];
  int t [6];
  int cres [4];
  int wr_count;

  function automatic int alu(input logic [2:0] cmd, input int a, input int b);
    case (cmd)
      CMD_ADD: return a + b;
      CMD_SUB: return a - b;
      CMD_MUL: return a * b;
      default: return 0;
    endcase
  endfunction

  function automatic int mul_op(input logic [1:0] sel, input int idx);
    if (sel == SRC_RAW) return raw[idx];
    if (sel == SRC_SUM) return s[idx];
    return BAD;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 0;
      for (int i = 0; i < 8; i++) mem[i] <= i + 1;  // A=[1,2;3,4], B=[5,6;7,8]
      wr_count <= 0;
    end else if (mem_we) begin
      mem[mem_addr1] <= wr_sel ? cres[2] : cres[0];
      mem[mem_addr2] <= wr_sel ? cres[3] : cres[1];
      wr_count <= wr_count + 1;
    end
    rd1_q <= mem[mem_addr1];
    rd2_q <= mem[mem_addr2];
    for (int k = 0; k < 4; k++)
      if (ld_en[k]) begin
        raw[2*k]   <= rd1_q;
        raw[2*k+1] <= rd2_q;
      end
    if (s_le)
      for (int k = 0; k < 10; k++)
        s[k] <= alu(alu_cmd[3*k +: 3],
                    (sel_a[2*k +: 2] == SRC_RAW) ? raw[SUM_A[k]] : BAD,
                    (sel_b[2*k +: 2] == SRC_RAW) ? raw[SUM_B[k]] : BAD);
    if (p_le)
      for (int k = 0; k < 7; k++)
        p[k] <= alu(alu_cmd[3*k +: 3], mul_op(sel_a[2*k +: 2], MUL_A[k]),
                    mul_op(sel_b[2*k +: 2], MUL_B[k]));
    if (t_le)
      for (int k = 0; k < 6; k++)
        t[k] <= alu(alu_cmd[3*k +: 3],
                    (sel_a[2*k +: 2] == SRC_PROD) ? p[CB1_A[k]] : BAD,
                    (sel_b[2*k +: 2] == SRC_PROD) ? p[CB1_B[k]] : BAD);
    if (c_le) begin
      cres[0] <= alu(alu_cmd[2:0], (sel_a[1:0] == SRC_PART) ? t[0] : BAD,
                     (sel_b[1:0] == SRC_PART) ? t[1] : BAD);
      cres[1] <= t[2];
      cres[2] <= t[3];
      cres[3] <= alu(alu_cmd[14:12], (sel_a[9:8] == SRC_PART) ? t[4] : BAD,
                     (sel_b[9:8] == SRC_PART) ? t[5] : BAD);
    end
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  task automatic init_mem();
    @(posedge clk); #1 mem_init = 1'b1;
    @(posedge clk); #1 mem_init = 1'b0;
  endtask

  task automatic accept_start();
    @(posedge clk); #1 start = 1'b1;
  endtask

  task automatic check_product(input string name, input int exp_writes);
    int exp_c [4] = '{19, 22, 43, 50};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8+i] !== exp_c[i]) begin
        errors++;
        $display("FAIL %s mem[%0d] got %0d exp %0d", name, 8 + i, mem[8+i], exp_c[i]);
      end
    end
    checks++;
    if (wr_count !== exp_writes) begin
      errors++;
      $display("FAIL %s write_cycles got %0d exp %0d", name, wr_count, exp_writes);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    mem_init = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({busy, done, mem_we, wr_sel, s_le, p_le, t_le, c_le, ld_en} !== 12'h000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0", {busy, done, mem_we, wr_sel, s_le, p_le, t_le, c_le, ld_en});
    end
    checks++;
    if (alu_cmd !== NOP_ALL) begin
      errors++;
      $display("FAIL reset_cmd got %h exp %h", alu_cmd, NOP_ALL);
    end
    checks++;
    if ({sel_a, sel_b, mem_addr1, mem_addr2} !== 48'h0) begin
      errors++;
      $display("FAIL reset_sel_addr got %h exp 0", {sel_a, sel_b, mem_addr1, mem_addr2});
    end
    reset = 1'b0;
    mem_init = 1'b0;
  endtask

  task automatic test_basic();
    logic [10:0] got, exp;
    logic [AW-1:0] ea;
    accept_start();
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1 start = 1'b0; #1;
      got = {busy, done, mem_we, s_le, p_le, t_le, c_le, ld_en};
      exp = {c <= 13, c == 13, c == 11 || c == 12, c == 6, c == 8, c == 9, c == 10,
             (c >= 2 && c <= 5) ? 4'(1 << (c - 2)) : 4'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic_ctrl c=%0d got %b exp %b", c, got, exp);
      end
      if (c <= 4 || c == 11 || c == 12) begin
        ea = (c <= 4) ? AW'(2 * (c - 1)) : AW'(8 + 2 * (c - 11));
        checks++;
        if ({mem_addr1, mem_addr2, wr_sel} !== {ea, ea + AW'(1), c == 12}) begin
          errors++;
          $display("FAIL basic_addr c=%0d got %0d/%0d ws=%b exp %0d/%0d", c, mem_addr1, mem_addr2, wr_sel, ea, ea + 1);
        end
      end
    end
    check_product("basic", 2);
  endtask

  task automatic test_back_to_back();
    int dones;
    accept_start();
    for (int c = 1; c <= 28; c++) begin
      @(posedge clk); #2;
      checks++;
      if ({busy, done} !== {!(c == 14 || c == 28), c == 13 || c == 27}) begin
        errors++;
        $display("FAIL b2b c=%0d got busy=%b done=%b", c, busy, done);
      end
      if (c == 27) start = 1'b0;
    end
    dones = 0;
    accept_start();
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1 start = (c == 5 || c == 9 || c == 13); #1;
      if (done) dones++;
      checks++;
      if (done !== (c == 13)) begin
        errors++;
        $display("FAIL ignore_start c=%0d got done=%b", c, done);
      end
    end
    start = 1'b0;
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_start_count got %0d exp 1", dones);
    end
  endtask

  task automatic test_stall_mul();
    init_mem();
    accept_start();
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1 start = 1'b0; stall = (c >= 7 && c <= 9); #1;
      checks++;
      if ({p_le, done} !== {c == 11, c == 16}) begin
        errors++;
        $display("FAIL stall_mul c=%0d got p_le=%b done=%b", c, p_le, done);
      end
      if (c >= 7 && c <= 11) begin
        checks++;
        if (alu_cmd !== MUL_WORD) begin
          errors++;
          $display("FAIL stall_mul_cmd c=%0d got %h exp %h", c, alu_cmd, MUL_WORD);
        end
      end
    end
    stall = 1'b0;
    check_product("stall_mul", 2);
  endtask

  task automatic test_stall_load();
    int exp_a [9] = '{0, 2, 4, 4, 0, 2, 4, 6, 0};
    logic [3:0] exp_ld [9] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
    init_mem();
    accept_start();
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1 start = 1'b0; stall = (c == 3 || c == 4); #1;
      if (c <= 8) begin
        checks++;
        if ({mem_addr1, mem_addr2} !== {AW'(exp_a[c-1]), AW'(exp_a[c-1] + 1)}) begin
          errors++;
          $display("FAIL stall_load_addr c=%0d got %0d/%0d exp %0d", c, mem_addr1, mem_addr2, exp_a[c-1]);
        end
      end
      if (c <= 9) begin
        checks++;
        if (ld_en !== exp_ld[c-1]) begin
          errors++;
          $display("FAIL stall_load_ld c=%0d got %b exp %b", c, ld_en, exp_ld[c-1]);
        end
      end
      checks++;
      if (done !== (c == 17)) begin
        errors++;
        $display("FAIL stall_load_done c=%0d got %b", c, done);
      end
    end
    stall = 1'b0;
    check_product("stall_load", 2);
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    init_mem();
    accept_start();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1 start = 1'b0; reset = (c == 11); #1;
      if (done) dones++;
      if (c == 12) begin
        checks++;
        if ({mem_we, busy, alu_cmd} !== {2'b00, NOP_ALL}) begin
          errors++;
          $display("FAIL reset_mid c=12 got we=%b busy=%b cmd=%h", mem_we, busy, alu_cmd);
        end
      end
    end
    reset = 1'b0;
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid_done got %0d exp 0", dones);
    end
    checks++;
    if (wr_count !== 1) begin
      errors++;
      $display("FAIL reset_mid_writes got %0d exp 1", wr_count);
    end
  endtask

  task automatic test_wrap();
    int exp_a [4] = '{14, 0, 4, 6};
    @(posedge clk); #1 start1 = 1'b1; start5 = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1 start1 = 1'b0; start5 = 1'b0; #1;
      if (c <= 4) begin
        checks++;
        if ({a1_1, a2_1, a1_5, a2_5} !== {AW'(exp_a[c-1]), AW'(exp_a[c-1] + 1), AW'(exp_a[c-1]), AW'(exp_a[c-1] + 1)}) begin
          errors++;
          $display("FAIL wrap_addr c=%0d got %0d/%0d %0d/%0d exp %0d", c, a1_1, a2_1, a1_5, a2_5, exp_a[c-1]);
        end
      end
      checks++;
      if ({done1, done5} !== {c == 12, c == 16}) begin
        errors++;
        $display("FAIL wrap_done c=%0d got done1=%b done5=%b", c, done1, done5);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall_mul();
    test_stall_load();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
